layer_priority_arbiter: RTL and testbench

Programmable, frame-synchronised pixel-layer arbiter that replaces the fixed priority chain in the VGA object mixing path. It accepts a drawing request and an RGB value per object layer, plus the background colour. It selects the winning layer through a runtime-configurable rank table with per-layer enable and blink. Configuration writes arrive through a valid/ready handshake into shadow registers and take effect only at the next frame start, so a frame is never drawn with a half-applied priority order.

---
 rtl/layer_priority_arbiter_if.sv | 34 +++
 rtl/layer_priority_arbiter.sv | 149 ++++++++++++++
 tb/tb_layer_priority_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_priority_arbiter_if.sv
// Pixel/config bundle for layer_priority_arbiter; master drives pixels and config writes,
// slave (the arbiter) returns the mixed pixel, winner info and the config handshake status.
interface layer_priority_arbiter_if #(
  parameter int LAYERS  = 8,
  parameter int IDX_W   = 3,
  parameter int BLINK_W = 4
);
  logic                        startOfFrame;
  logic [LAYERS-1:0]           layerDR;
  logic [LAYERS-1:0][7:0]      layerRGB;
  logic [7:0]                  backGroundRGB;
  logic                        cfgValid;
  logic                        cfgReady;
  logic [IDX_W-1:0]            cfgLayer;
  logic [IDX_W-1:0]            cfgRank;
  logic                        cfgEnable;
  logic [BLINK_W-1:0]          cfgBlink;
  logic [7:0]                  RGBOut;
  logic                        winnerValid;
  logic [IDX_W-1:0]            winnerLayer;
  logic                        cfgPending;

  modport master (
    output startOfFrame, layerDR, layerRGB, backGroundRGB,
    output cfgValid, cfgLayer, cfgRank, cfgEnable, cfgBlink,
    input  cfgReady, RGBOut, winnerValid, winnerLayer, cfgPending
  );

  modport slave (
    input  startOfFrame, layerDR, layerRGB, backGroundRGB,
    input  cfgValid, cfgLayer, cfgRank, cfgEnable, cfgBlink,
    output cfgReady, RGBOut, winnerValid, winnerLayer, cfgPending
  );
endinterface

// File: rtl/layer_priority_arbiter.sv
// Rank-table pixel-layer arbiter, 2-cycle latency, one pixel per cycle with no stalls;
// config writes land in shadow regs and commit at frame start, cfgReady drops only in the commit cycle.
module layer_priority_arbiter #(
  parameter int LAYERS  = 8,
  parameter int IDX_W   = 3,
  parameter int BLINK_W = 4
) (
  input logic                    clk,
  input logic                    resetN,
  layer_priority_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PENDING = 2'd1, S_COMMIT = 2'd2} state_t;

  localparam logic [IDX_W:0] LAYERS_W = (IDX_W + 1)'(LAYERS);

  state_t r_state, w_state_nxt;
  logic   w_cfg_rdy, w_cfg_pending, w_wr_ok;

  logic [IDX_W-1:0]   r_act_rank  [LAYERS];
  logic [IDX_W-1:0]   r_shd_rank  [LAYERS];
  logic [BLINK_W-1:0] r_act_blink [LAYERS];
  logic [BLINK_W-1:0] r_shd_blink [LAYERS];
  logic [LAYERS-1:0]  r_act_en, r_shd_en;
  logic [7:0]         r_frame_cnt;

  logic [LAYERS-1:0]      w_visible;
  logic [LAYERS-1:0]      r_s1_elig;
  logic [LAYERS-1:0][7:0] r_s1_rgb;
  logic [7:0]             r_s1_bg;
  logic [IDX_W-1:0]       r_s1_rank [LAYERS];

  logic             w_win_vld;
  logic [IDX_W-1:0] w_win_idx, w_win_rank;
  logic [7:0]       w_win_rgb;

  // Out-of-range layer indices complete the handshake but touch nothing.
  assign w_wr_ok = bus.cfgValid & w_cfg_rdy & ({1'b0, bus.cfgLayer} < LAYERS_W);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_wr_ok)          w_state_nxt = S_PENDING;
      S_PENDING: if (bus.startOfFrame) w_state_nxt = S_COMMIT;
      S_COMMIT:                        w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cfg_rdy     = (r_state != S_COMMIT);
    w_cfg_pending = (r_state != S_IDLE);
  end

  assign bus.cfgReady   = w_cfg_rdy;
  assign bus.cfgPending = w_cfg_pending;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < LAYERS; i++) begin
        r_act_rank[i]  <= IDX_W'(i);
        r_shd_rank[i]  <= IDX_W'(i);
        r_act_blink[i] <= '0;
        r_shd_blink[i] <= '0;
      end
      r_act_en <= '1;
      r_shd_en <= '1;
    end else begin
      for (int i = 0; i < LAYERS; i++) begin
        if (w_wr_ok && bus.cfgLayer == IDX_W'(i)) begin
          r_shd_rank[i]  <= bus.cfgRank;
          r_shd_blink[i] <= bus.cfgBlink;
          r_shd_en[i]    <= bus.cfgEnable;
        end
        if (r_state == S_COMMIT) begin
          r_act_rank[i]  <= r_shd_rank[i];
          r_act_blink[i] <= r_shd_blink[i];
          r_act_en[i]    <= r_shd_en[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)               r_frame_cnt <= '0;
    else if (bus.startOfFrame) r_frame_cnt <= r_frame_cnt + 8'd1;
  end

  // Blink code n watches frame-counter bit n-1; codes of 8 and above all use bit 7.
  always_comb begin
    w_visible = '1;
    for (int i = 0; i < LAYERS; i++) begin
      if (r_act_blink[i] != '0) begin
        w_visible[i] = ~r_frame_cnt[7];
        for (int k = 1; k < 8; k++)
          if (int'(r_act_blink[i]) == k) w_visible[i] = ~r_frame_cnt[k-1];
      end
    end
  end

  // Ranks travel with the pixel so a commit never splits a pixel across two configs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_s1_elig <= '0;
      r_s1_rgb  <= '0;
      r_s1_bg   <= '0;
      for (int i = 0; i < LAYERS; i++) r_s1_rank[i] <= '0;
    end else begin
      r_s1_elig <= bus.layerDR & r_act_en & w_visible;
      r_s1_rgb  <= bus.layerRGB;
      r_s1_bg   <= bus.backGroundRGB;
      for (int i = 0; i < LAYERS; i++) r_s1_rank[i] <= r_act_rank[i];
    end
  end

  // Ascending scan with strict '<' leaves the lowest index holding a tied rank.
  always_comb begin
    w_win_vld  = 1'b0;
    w_win_idx  = '0;
    w_win_rank = '0;
    w_win_rgb  = r_s1_bg;
    for (int i = 0; i < LAYERS; i++) begin
      if (r_s1_elig[i] && (!w_win_vld || r_s1_rank[i] < w_win_rank)) begin
        w_win_vld  = 1'b1;
        w_win_idx  = IDX_W'(i);
        w_win_rank = r_s1_rank[i];
        w_win_rgb  = r_s1_rgb[i];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bus.RGBOut      <= '0;
      bus.winnerValid <= 1'b0;
      bus.winnerLayer <= '0;
    end else begin
      bus.RGBOut      <= w_win_rgb;
      bus.winnerValid <= w_win_vld;
      bus.winnerLayer <= w_win_idx;
    end
  end

endmodule

// File: tb/tb_layer_priority_arbiter.sv
// Bench for layer_priority_arbiter: vector table, directed frame/commit sequences,
// then random traffic against a rule-level model.
module tb_layer_priority_arbiter;
  localparam int L  = 8;
  localparam int IW = 3;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  layer_priority_arbiter_if #(.LAYERS(L), .IDX_W(IW), .BLINK_W(BW)) bus ();
  layer_priority_arbiter #(.LAYERS(L), .IDX_W(IW), .BLINK_W(BW)) dut (
    .clk(clk), .resetN(resetN), .bus(bus));

  layer_priority_arbiter_if #(.LAYERS(6), .IDX_W(IW), .BLINK_W(BW)) bus6 ();
  layer_priority_arbiter #(.LAYERS(6), .IDX_W(IW), .BLINK_W(BW)) dut6 (
    .clk(clk), .resetN(resetN), .bus(bus6));

  int checks = 0;
  int errors = 0;
  int tb_fc  = 0;

  // Model: active/shadow tables, commit phase (0 none, 1 waiting for frame, 2 copying now).
  int m_rank[L], m_en[L], m_blink[L];
  int s_rank[L], s_en[L], s_blink[L];
  int m_phase, m_fc;
  int p_rgb, p_vld, p_idx;
  int e_rgb, e_vld, e_idx;

  logic [7:0] rgb_init [L];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < L; i++) begin
      m_rank[i] = i; m_en[i] = 1; m_blink[i] = 0;
      s_rank[i] = i; s_en[i] = 1; s_blink[i] = 0;
    end
    m_phase = 0; m_fc = 0;
    p_rgb = 0; p_vld = 0; p_idx = 0;
    e_rgb = 0; e_vld = 0; e_idx = 0;
  endfunction

  function automatic int visible(int ly);
    int p;
    if (m_blink[ly] == 0) return 1;
    p = (m_blink[ly] > 8) ? 8 : m_blink[ly];
    return (((m_fc >> (p - 1)) & 1) == 0) ? 1 : 0;
  endfunction

  // Applied once per rising edge with the inputs that edge sampled.
  function automatic void model_edge();
    int found, w;
    found = 0; w = 0;
    for (int r = 0; r < (1 << IW) && !found; r++)
      for (int i = 0; i < L && !found; i++)
        if (bus.layerDR[i] && m_en[i] != 0 && visible(i) != 0 && m_rank[i] == r) begin
          found = 1; w = i;
        end
    e_rgb = p_rgb; e_vld = p_vld; e_idx = p_idx;
    p_vld = found;
    p_idx = found ? w : 0;
    p_rgb = found ? int'(bus.layerRGB[w]) : int'(bus.backGroundRGB);
    if (m_phase == 2) begin
      for (int i = 0; i < L; i++) begin
        m_rank[i] = s_rank[i]; m_en[i] = s_en[i]; m_blink[i] = s_blink[i];
      end
      m_phase = 0;
    end else begin
      if (bus.cfgValid && int'(bus.cfgLayer) < L) begin
        s_rank[bus.cfgLayer]  = int'(bus.cfgRank);
        s_en[bus.cfgLayer]    = int'(bus.cfgEnable);
        s_blink[bus.cfgLayer] = int'(bus.cfgBlink);
        if (m_phase == 0) m_phase = 1;
        else if (bus.startOfFrame) m_phase = 2;
      end else if (m_phase == 1 && bus.startOfFrame) begin
        m_phase = 2;
      end
    end
    if (bus.startOfFrame) m_fc = (m_fc + 1) % 256;
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("mdl_rgb", bus.RGBOut, e_rgb);
    chk("mdl_vld", bus.winnerValid, e_vld);
    chk("mdl_idx", bus.winnerLayer, e_idx);
    chk("mdl_ready", bus.cfgReady, (m_phase != 2));
    chk("mdl_pending", bus.cfgPending, (m_phase != 0));
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    model_reset();
    tb_fc = 0;
    #1;
    chk("rst_rgb", bus.RGBOut, 0);
    chk("rst_vld", bus.winnerValid, 0);
    chk("rst_idx", bus.winnerLayer, 0);
    chk("rst_ready", bus.cfgReady, 1);
    chk("rst_pending", bus.cfgPending, 0);
    @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic cfg_write(input int ly, input int rk, input int en, input int bl, input bit sof);
    bus.cfgValid = 1'b1; bus.cfgLayer = IW'(ly); bus.cfgRank = IW'(rk);
    bus.cfgEnable = 1'(en); bus.cfgBlink = BW'(bl); bus.startOfFrame = sof;
    cyc();
    bus.cfgValid = 1'b0; bus.startOfFrame = 1'b0;
    if (sof) tb_fc = (tb_fc + 1) % 256;
  endtask

  task automatic sof_burst(input int n);
    bus.startOfFrame = 1'b1;
    repeat (n) cyc();
    bus.startOfFrame = 1'b0;
    tb_fc = (tb_fc + n) % 256;
    repeat (5) cyc();
  endtask

  typedef struct {
    logic [7:0] dr;
    logic [7:0] bg;
    logic [7:0] exp_rgb;
    logic       exp_vld;
    logic [2:0] exp_idx;
  } vec_t;

  vec_t tab [7];
  int   ready_low;

  initial begin
    rgb_init = '{8'h11, 8'hE0, 8'h1C, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    tab[0] = '{8'b0000_0110, 8'h00, 8'hE0, 1'b1, 3'd1};
    tab[1] = '{8'b0000_0000, 8'h03, 8'h03, 1'b0, 3'd0};
    tab[2] = '{8'b1000_0000, 8'h55, 8'h77, 1'b1, 3'd7};
    tab[3] = '{8'b1000_0001, 8'h55, 8'h11, 1'b1, 3'd0};
    tab[4] = '{8'b1111_1100, 8'h03, 8'h1C, 1'b1, 3'd2};
    tab[5] = '{8'b0011_0000, 8'h03, 8'h44, 1'b1, 3'd4};
    tab[6] = '{8'b0000_0000, 8'hAA, 8'hAA, 1'b0, 3'd0};

    bus.startOfFrame = 0; bus.layerDR = '0; bus.backGroundRGB = '0;
    bus.cfgValid = 0; bus.cfgLayer = '0; bus.cfgRank = '0; bus.cfgEnable = 0; bus.cfgBlink = '0;
    for (int i = 0; i < L; i++) bus.layerRGB[i] = rgb_init[i];
    bus6.startOfFrame = 0; bus6.layerDR = 6'b00_0110; bus6.backGroundRGB = 8'h03;
    bus6.cfgValid = 0; bus6.cfgLayer = '0; bus6.cfgRank = '0; bus6.cfgEnable = 0; bus6.cfgBlink = '0;
    for (int i = 0; i < 6; i++) bus6.layerRGB[i] = rgb_init[i];
    resetN = 1'b1;
    @(negedge clk);
    do_reset();

    // Default ranks: lowest requesting index wins.
    for (int v = 0; v < 7; v++) begin
      bus.layerDR = tab[v].dr; bus.backGroundRGB = tab[v].bg;
      cyc(); cyc();
      chk("vec_rgb", bus.RGBOut, tab[v].exp_rgb);
      chk("vec_vld", bus.winnerValid, tab[v].exp_vld);
      chk("vec_idx", bus.winnerLayer, tab[v].exp_idx);
    end

    // Reprioritise: layer 2 to rank 0, applied only at frame start.
    bus.layerDR = 8'b0000_0110; bus.backGroundRGB = 8'h03;
    cfg_write(2, 0, 1, 0, 0);
    chk("reprio_pending", bus.cfgPending, 1);
    repeat (3) begin cyc(); chk("reprio_hold", bus.RGBOut, 8'hE0); end
    bus.startOfFrame = 1; cyc(); bus.startOfFrame = 0; tb_fc++;
    ready_low = (bus.cfgReady == 1'b0) ? 1 : 0;
    repeat (5) begin cyc(); if (bus.cfgReady == 1'b0) ready_low++; end
    chk("commit_ready_low_cycles", ready_low, 1);
    chk("reprio_rgb", bus.RGBOut, 8'h1C);
    chk("reprio_idx", bus.winnerLayer, 2);
    chk("reprio_pending_clr", bus.cfgPending, 0);

    // Tie goes to lower index; disabling layer 1 hands it to layer 2.
    cfg_write(1, 0, 1, 0, 0); cfg_write(2, 0, 1, 0, 0); sof_burst(1);
    chk("tie_idx", bus.winnerLayer, 1);
    chk("tie_rgb", bus.RGBOut, 8'hE0);
    cfg_write(1, 0, 0, 0, 0); sof_burst(1);
    chk("dis_idx", bus.winnerLayer, 2);
    chk("dis_rgb", bus.RGBOut, 8'h1C);

    // Blink.
    do_reset();
    bus.layerDR = 8'b0000_0010; bus.backGroundRGB = 8'h03;
    cfg_write(1, 1, 1, 1, 0); sof_burst(1);
    repeat (4) begin
      sof_burst(1);
      chk("blink1", bus.RGBOut, (tb_fc % 2 == 0) ? 8'hE0 : 8'h03);
    end
    cfg_write(1, 1, 1, 15, 0); sof_burst(1);
    sof_burst((127 - tb_fc + 256) % 256); chk("blink15_127", bus.RGBOut, 8'hE0);
    sof_burst(1);   chk("blink15_128", bus.RGBOut, 8'h03);
    sof_burst(127); chk("blink15_255", bus.RGBOut, 8'h03);
    sof_burst(1);   chk("blink15_wrap", bus.RGBOut, 8'hE0);
    cfg_write(1, 1, 1, 8, 0); sof_burst(1);
    chk("blink8_1", bus.RGBOut, 8'hE0);
    sof_burst(127); chk("blink8_128", bus.RGBOut, 8'h03);

    // Write coinciding with frame start while pending: part of this commit.
    do_reset();
    bus.layerDR = 8'b0000_0110; bus.backGroundRGB = 8'h03;
    cfg_write(3, 5, 1, 0, 0);
    cfg_write(2, 0, 1, 0, 1);
    repeat (5) cyc();
    chk("sof_pend_idx", bus.winnerLayer, 2);
    chk("sof_pend_pending", bus.cfgPending, 0);

    // Same write while idle: waits for the following frame.
    do_reset();
    bus.layerDR = 8'b0000_0110; bus.backGroundRGB = 8'h03;
    cfg_write(2, 0, 1, 0, 1);
    repeat (5) cyc();
    chk("sof_idle_pending", bus.cfgPending, 1);
    chk("sof_idle_old", bus.winnerLayer, 1);
    sof_burst(1);
    chk("sof_idle_new", bus.winnerLayer, 2);

    // Six-layer instance: layer 7 write is accepted but ignored.
    bus6.cfgValid = 1; bus6.cfgLayer = 3'd7; bus6.cfgRank = 3'd0; bus6.cfgEnable = 0;
    #1 chk("l6_ready", bus6.cfgReady, 1);
    cyc();
    bus6.cfgValid = 0;
    chk("l6_pending", bus6.cfgPending, 0);
    bus6.startOfFrame = 1; cyc(); bus6.startOfFrame = 0;
    repeat (4) cyc();
    chk("l6_idx", bus6.winnerLayer, 1);
    chk("l6_rgb", bus6.RGBOut, 8'hE0);

    // Reset discards a pending write.
    cfg_write(0, 0, 1, 0, 0);
    do_reset();
    bus.layerDR = 8'b0000_0110;
    cfg_write(2, 0, 1, 0, 0);
    chk("rstpend_pending", bus.cfgPending, 1);
    do_reset();
    sof_burst(1);
    chk("rstpend_idx", bus.winnerLayer, 1);
    chk("rstpend_rgb", bus.RGBOut, 8'hE0);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      bus.layerDR = 8'($urandom);
      bus.backGroundRGB = 8'($urandom);
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < L; i++) bus.layerRGB[i] = 8'($urandom);
      bus.startOfFrame = ($urandom_range(0, 7) == 0);
      bus.cfgValid  = ($urandom_range(0, 3) == 0);
      bus.cfgLayer  = IW'($urandom);
      bus.cfgRank   = IW'($urandom);
      bus.cfgEnable = ($urandom_range(0, 4) != 0);
      bus.cfgBlink  = ($urandom_range(0, 1) == 0) ? '0 : BW'($urandom_range(1, 4));
      if ($urandom_range(0, 15) == 0) bus.cfgBlink = BW'($urandom);
      if ($urandom_range(0, 999) == 0) do_reset();
      else cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
